// File: rtl/instr_fetch_unit.sv
// Fetch stage with IF/ID pipeline register: PC, JMP resolution in fetch,
// stall hold and branch redirect/flush from a later stage.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic [15:0] jump_count
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned JCNT_W   = 16;
    localparam logic [OPC_W-1:0] OPC_JMP = OPC_W'(8);

    logic [XLEN-1:0]   pc_q,          pc_d;
    logic [XLEN-1:0]   if_id_instr_q, if_id_instr_d;
    logic [XLEN-1:0]   if_id_pc4_q,   if_id_pc4_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [JCNT_W-1:0] jump_count_q,  jump_count_d;

    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   jmp_target;
    logic              fetch_is_jmp;
    logic              unused_target_lsbs;

    assign pc4                = pc_q + XLEN'(4);
    assign jmp_target         = {pc4[31:28], imem_rdata[25:0], 2'b00};
    assign fetch_is_jmp       = (imem_rdata[31:26] == OPC_JMP);
    // Redirect addresses are forced word aligned; the low bits are don't-care.
    assign unused_target_lsbs = ^branch_target[1:0];

    // Next-state selection: redirect > stall > JMP > sequential fetch.
    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        jump_count_d  = jump_count_q;

        if (branch_taken) begin
            pc_d          = {branch_target[31:2], 2'b00};
            if_id_instr_d = NOP_WORD;
            if_id_pc4_d   = '0;
            if_id_valid_d = 1'b0;
        end else if (stall) begin
            pc_d          = pc_q;
        end else if (fetch_is_jmp) begin
            pc_d          = jmp_target;
            if_id_instr_d = NOP_WORD;
            if_id_pc4_d   = pc4;
            if_id_valid_d = 1'b0;
            jump_count_d  = jump_count_q + JCNT_W'(1);
        end else begin
            pc_d          = pc4;
            if_id_instr_d = imem_rdata;
            if_id_pc4_d   = pc4;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP_WORD;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
            jump_count_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            jump_count_q  <= jump_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;
    assign opcode      = if_id_instr_q[31:26];
    assign jump_count  = jump_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational instruction memory model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;
    logic [15:0] jump_count;

    logic        ovr_en;
    logic [31:0] ovr_addr;
    logic [31:0] ovr_word;

    int unsigned n_vec;
    int unsigned n_err;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .opcode       (opcode),
        .jump_count   (jump_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns 0x0400_0000|addr, except one overridable location.
    always_comb begin
        imem_rdata = 32'h0400_0000 | imem_addr;
        if (ovr_en && imem_addr == ovr_addr) imem_rdata = ovr_word;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, ".pc"},    imem_addr,          pc);
        check({tag, ".instr"}, if_id_instr,        instr);
        check({tag, ".pc4"},   if_id_pc4,          pc4);
        check({tag, ".valid"}, 32'(if_id_valid),   32'(valid));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        ovr_en = 1'b0; ovr_addr = '0; ovr_word = '0;

        // Reset state
        tick();
        check_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        check("rst.opcode", 32'(opcode), 32'h0);
        check("rst.jcnt", 32'(jump_count), 32'h0);
        rst = 1'b0;

        // Sequential fetch
        tick();
        check_ifid("seq0", 32'h4, 32'h0400_0000, 32'h4, 1'b1);
        check("seq0.opcode", 32'(opcode), 32'h1);
        tick();
        check_ifid("seq1", 32'h8, 32'h0400_0004, 32'h8, 1'b1);

        // Stall holds everything for three edges
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ifid("stall", 32'h8, 32'h0400_0004, 32'h8, 1'b1);
        end
        stall = 1'b0;
        tick();
        check_ifid("resume", 32'hC, 32'h0400_0008, 32'hC, 1'b1);

        // Branch beats stall, low target bits dropped
        branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h0000_0043;
        tick();
        check_ifid("br", 32'h40, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0; stall = 1'b0;
        tick();
        check_ifid("br_tgt", 32'h44, 32'h0400_0040, 32'h44, 1'b1);

        // JMP in fetch
        branch_taken = 1'b1; branch_target = 32'h1000_0010;
        tick();
        branch_taken = 1'b0;
        ovr_en = 1'b1; ovr_addr = 32'h1000_0010; ovr_word = 32'h2000_0100;
        check("jmp_pre.pc", imem_addr, 32'h1000_0010);
        tick();
        check_ifid("jmp", 32'h1000_0400, 32'h0, 32'h1000_0014, 1'b0);
        check("jmp.jcnt", 32'(jump_count), 32'h1);
        tick();
        check_ifid("jmp_tgt", 32'h1000_0404, 32'h1400_0400, 32'h1000_0404, 1'b1);

        // JMP coinciding with branch: branch wins, count unchanged
        branch_taken = 1'b1; branch_target = 32'h1000_0010;
        tick();
        branch_target = 32'h0000_0200;
        tick();
        branch_taken = 1'b0;
        check_ifid("jmp_br", 32'h200, 32'h0, 32'h0, 1'b0);
        check("jmp_br.jcnt", 32'(jump_count), 32'h1);
        tick();
        check_ifid("jmp_br_seq", 32'h204, 32'h0400_0200, 32'h204, 1'b1);

        // PC wrap-around
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        tick();
        branch_taken = 1'b0;
        check("wrap_pre.pc", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
        check("wrap.opcode", 32'(opcode), 32'h3F);

        // Reset wins over stall and redirect together
        rst = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0800;
        tick();
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        check_ifid("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0);
        check("rst_mid.jcnt", 32'(jump_count), 32'h0);

        // Self-looping JMP at 0x40: 65536 iterations wrap the counter
        ovr_addr = 32'h40; ovr_word = 32'h2000_0010;
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        tick();
        check_ifid("loop1", 32'h40, 32'h0, 32'h44, 1'b0);
        check("loop1.jcnt", 32'(jump_count), 32'h1);
        for (int i = 1; i < 65535; i++) tick();
        check("loop_ffff.jcnt", 32'(jump_count), 32'hFFFF);
        tick();
        check("loop_wrap.jcnt", 32'(jump_count), 32'h0);
        check("loop_wrap.pc", imem_addr, 32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
